// File: rtl/hazard_control_unit.sv
// Hazard sequencer for the five-stage RV32I core: load-use bubbles, branch flushes, cache-miss holds with timeout.
// Stall/clear outputs are combinational from stage fields and state; perf counters saturate.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT_CYCLES = 64,
  parameter int COUNTER_WIDTH      = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [4:0]               RS1_ADDRESS_ID,
  input  logic [4:0]               RS2_ADDRESS_ID,
  input  logic                     RS1_USED_ID,
  input  logic                     RS2_USED_ID,
  input  logic [4:0]               RD_ADDRESS_EX,
  input  logic [2:0]               DATA_CACHE_LOAD_EX,
  input  logic                     RD_WRITE_ENABLE_EX,
  input  logic                     BRANCH_TAKEN_EX,
  input  logic                     DATA_CACHE_REQUEST_MEM,
  input  logic                     DATA_CACHE_READY,
  output logic                     STALL_FETCH_STAGE,
  output logic                     STALL_DECODING_STAGE,
  output logic                     CLEAR_DECODING_STAGE,
  output logic                     STALL_EXECUTION_STAGE,
  output logic                     CLEAR_EXECUTION_STAGE,
  output logic                     STALL_MEMORY_STAGE,
  output logic                     MEM_TIMEOUT_ERROR,
  output logic [COUNTER_WIDTH-1:0] STALL_CYCLE_COUNT,
  output logic [COUNTER_WIDTH-1:0] FLUSH_COUNT
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [WAIT_W-1:0]        WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]        WAIT_LAST = WAIT_W'(MEM_TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              miss;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              flush;

  assign miss    = DATA_CACHE_REQUEST_MEM & ~DATA_CACHE_READY;
  assign rs1_hit = RS1_USED_ID & (RS1_ADDRESS_ID == RD_ADDRESS_EX);
  assign rs2_hit = RS2_USED_ID & (RS2_ADDRESS_ID == RD_ADDRESS_EX);
  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use = (DATA_CACHE_LOAD_EX != 3'b000) & RD_WRITE_ENABLE_EX &
                    (RD_ADDRESS_EX != 5'd0) & (rs1_hit | rs2_hit);

  assign MEM_TIMEOUT_ERROR = (state == ST_ERROR);

  always_comb begin
    STALL_FETCH_STAGE     = 1'b0;
    STALL_DECODING_STAGE  = 1'b0;
    CLEAR_DECODING_STAGE  = 1'b0;
    STALL_EXECUTION_STAGE = 1'b0;
    CLEAR_EXECUTION_STAGE = 1'b0;
    STALL_MEMORY_STAGE    = 1'b0;
    flush                 = 1'b0;
    if (!RESET_N) begin
      CLEAR_DECODING_STAGE  = 1'b1;
      CLEAR_EXECUTION_STAGE = 1'b1;
    end else if (state == ST_ERROR || miss) begin
      STALL_FETCH_STAGE     = 1'b1;
      STALL_DECODING_STAGE  = 1'b1;
      STALL_EXECUTION_STAGE = 1'b1;
      STALL_MEMORY_STAGE    = 1'b1;
    end else if (BRANCH_TAKEN_EX) begin
      // Wrong-path consumer in ID makes any load-use stall moot.
      CLEAR_DECODING_STAGE  = 1'b1;
      CLEAR_EXECUTION_STAGE = 1'b1;
      flush                 = 1'b1;
    end else if (load_use) begin
      STALL_FETCH_STAGE     = 1'b1;
      STALL_DECODING_STAGE  = 1'b1;
      CLEAR_EXECUTION_STAGE = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (miss) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (!miss) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      STALL_CYCLE_COUNT <= '0;
      FLUSH_COUNT       <= '0;
    end else begin
      if (STALL_DECODING_STAGE && STALL_CYCLE_COUNT != CNT_MAX)
        STALL_CYCLE_COUNT <= STALL_CYCLE_COUNT + CNT_ONE;
      if (flush && FLUSH_COUNT != CNT_MAX)
        FLUSH_COUNT <= FLUSH_COUNT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a 4-cycle timeout and 3-bit counters.
module tb_hazard_control_unit;

  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [4:0]    rs1, rs2, rd;
  logic          u1, u2, we, br, req, rdy;
  logic [2:0]    ld;
  logic          sf, sd, cd, se, ce, sm, err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [5:0]    outs;

  int total = 0;
  int bad   = 0;

  // Output vector order: {stall_f, stall_d, clear_d, stall_e, clear_e, stall_m}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_RST   = 6'b001010;
  localparam logic [5:0] O_FLUSH = 6'b001010;
  localparam logic [5:0] O_LU    = 6'b110010;
  localparam logic [5:0] O_HOLD  = 6'b110101;

  assign outs = {sf, sd, cd, se, ce, sm};

  always #5 CLK = ~CLK;

  hazard_control_unit #(.MEM_TIMEOUT_CYCLES(4), .COUNTER_WIDTH(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .RS1_ADDRESS_ID(rs1), .RS2_ADDRESS_ID(rs2),
    .RS1_USED_ID(u1), .RS2_USED_ID(u2),
    .RD_ADDRESS_EX(rd), .DATA_CACHE_LOAD_EX(ld), .RD_WRITE_ENABLE_EX(we),
    .BRANCH_TAKEN_EX(br), .DATA_CACHE_REQUEST_MEM(req), .DATA_CACHE_READY(rdy),
    .STALL_FETCH_STAGE(sf), .STALL_DECODING_STAGE(sd), .CLEAR_DECODING_STAGE(cd),
    .STALL_EXECUTION_STAGE(se), .CLEAR_EXECUTION_STAGE(ce), .STALL_MEMORY_STAGE(sm),
    .MEM_TIMEOUT_ERROR(err), .STALL_CYCLE_COUNT(stall_cnt), .FLUSH_COUNT(flush_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic i_req, input logic i_rdy, input logic i_br,
                       input logic [2:0] i_ld, input logic i_we, input logic [4:0] i_rd,
                       input logic [4:0] i_rs1, input logic i_u1,
                       input logic [4:0] i_rs2, input logic i_u2);
    req = i_req; rdy = i_rdy; br = i_br; ld = i_ld; we = i_we; rd = i_rd;
    rs1 = i_rs1; u1 = i_u1; rs2 = i_rs2; u2 = i_u2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RESET_N = 1'b0;
    drive(1, 0, 1, 3'b010, 1, 5, 5, 1, 0, 0);
    #3;
    check("rst_outs", outs, O_RST);
    check("rst_err", err, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    tick();
    check("rst_outs_edge", outs, O_RST);
    check("rst_stall_cnt_edge", stall_cnt, 0);

    idle();
    RESET_N = 1'b1;
    @(negedge CLK); check("idle", outs, O_NONE); tick();

    // Load-use on rs1, then the load moves on
    drive(0, 0, 0, 3'b010, 1, 5, 5, 1, 0, 0);
    @(negedge CLK); check("lu_rs1", outs, O_LU); tick();
    idle();
    @(negedge CLK); check("lu_drop", outs, O_NONE); check("lu_cnt1", stall_cnt, 1); tick();
    drive(0, 0, 0, 3'b010, 1, 0, 0, 1, 0, 0);
    @(negedge CLK); check("lu_x0", outs, O_NONE); tick();
    drive(0, 0, 0, 3'b010, 1, 5, 5, 0, 0, 0);
    @(negedge CLK); check("lu_unused", outs, O_NONE); tick();
    drive(0, 0, 0, 3'b100, 1, 7, 3, 1, 7, 1);
    @(negedge CLK); check("lu_rs2", outs, O_LU); tick();
    drive(0, 0, 0, 3'b000, 1, 7, 7, 1, 7, 1);
    @(negedge CLK); check("lu_noload", outs, O_NONE); check("lu_cnt2", stall_cnt, 2); tick();
    drive(0, 0, 0, 3'b010, 0, 7, 7, 1, 7, 1);
    @(negedge CLK); check("lu_nowe", outs, O_NONE); tick();

    // Branch outranks load-use
    drive(0, 0, 1, 3'b010, 1, 5, 5, 1, 0, 0);
    @(negedge CLK); check("br_over_lu", outs, O_FLUSH); tick();
    idle();
    @(negedge CLK); check("br_flush_cnt", flush_cnt, 1); check("br_stall_cnt", stall_cnt, 2); tick();

    // Three-cycle miss with a taken branch held in EX
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0);
      @(negedge CLK); check("miss_hold", outs, O_HOLD); tick();
    end
    drive(1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    check("miss_release", outs, O_FLUSH);
    check("miss_stall_cnt", stall_cnt, 5);
    check("miss_flush_cnt", flush_cnt, 1);
    tick();
    idle();
    @(negedge CLK);
    check("no_timeout_err", err, 0);
    check("after_release", outs, O_NONE);
    check("release_flush_cnt", flush_cnt, 2);
    tick();

    // Saturation of the stall counter
    drive(0, 0, 0, 3'b010, 1, 9, 9, 1, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    @(negedge CLK); check("sat_stall_cnt", stall_cnt, 7); check("sat_outs", outs, O_LU);
    tick();
    @(negedge CLK); check("sat_hold", stall_cnt, 7);
    idle();
    tick();

    RESET_N = 1'b0;
    #2;
    check("pulse_stall_cnt", stall_cnt, 0);
    check("pulse_flush_cnt", flush_cnt, 0);
    RESET_N = 1'b1;
    tick();

    // Four-cycle miss times out
    drive(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("to_pre_err", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_stall_cnt", stall_cnt, 4);
    drive(1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); check("err_hold_ready", outs, O_HOLD); check("err_sticky", err, 1); tick();
    idle();
    @(negedge CLK); check("err_hold_idle", outs, O_HOLD); check("err_stall_cnt", stall_cnt, 5); tick();

    // Async reset between edges out of ERROR with a miss still driven
    drive(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_outs", outs, O_RST);
    check("arst_err", err, 0);
    check("arst_stall_cnt", stall_cnt, 0);
    RESET_N = 1'b1;
    #1;
    check("arst_rel_miss", outs, O_HOLD);
    tick();
    tick();
    // Reset in MEM_WAIT must clear the wait counter
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_wait_outs", outs, O_RST);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("wait_cnt_cleared", err, 0);
    check("post_rst_stall_cnt", stall_cnt, 3);
    idle();
    tick();
    @(negedge CLK); check("final_outs", outs, O_NONE); check("final_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
